freq_bin2bcd_seq: RTL
=====================

Name: freq_bin2bcd_seq

Overview:
- Sequential shift-and-add-3 (double-dabble) binary-to-BCD converter for the frequency counter display path.
- Sits between the gated pulse counter (20-bit binary count) and the digit multiplexer / seven-segment decoder.
- Converts one bit per clock, replacing the wide combinational converter to save LUTs.
- Start/busy/valid handshake; reports and handles values exceeding the display range.

Parameters:
- BIN_W, 20, width of the binary input count.
- DIGITS, 4, number of BCD digits produced; BCD width = 4*DIGITS.

Ports:
- CLK  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request a conversion of bnum; sampled only in IDLE.
- bnum  input  BIN_W  binary value; captured on the accepting edge, need not be held.
- busy  output  1  high while a conversion is in progress (SHIFT or DONE).
- valid  output  1  one-cycle pulse when BCD/ovf are updated.
- BCD  output  4*DIGITS  packed BCD result; digit 0 in [3:0]; held between conversions.
- ovf  output  1  bnum >= 10^DIGITS for the latest result; held with BCD.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, BCD=0, ovf=0, valid=0, busy=0, internal shift/accumulator/counter cleared. Takes effect immediately mid-conversion; the partial result is discarded and outputs read 0 after reset.
- States: IDLE, SHIFT, DONE.
- IDLE: if start=1 at an edge (edge 0), latch bnum into the shift register, clear the accumulator, clear the sticky carry, set bit counter=0, go to SHIFT. busy=1 from edge 0.
- SHIFT: each edge, first add 3 to every accumulator nibble >= 5, then shift {accumulator, shift register} left by 1. Any 1 shifted out of the top digit sets the sticky carry. Increment the counter. On the edge where counter = BIN_W-1 (edge BIN_W), go to DONE. Exactly BIN_W shift cycles.
- DONE: at edge BIN_W+1, load BCD (see Optional Feature), load ovf from the sticky carry, assert valid for exactly one cycle, deassert busy, and return to IDLE.
- Latency: start sampled at edge 0 -> valid/BCD visible after edge BIN_W+1 (edge 21 by default). A new start is accepted at edge BIN_W+2 at the earliest. Throughput is one conversion per BIN_W+2 cycles.
- start while busy=1 is ignored: not queued, and does not disturb the current conversion or the captured value.
- Changes on bnum after capture have no effect.
- Carry arithmetic: without saturation, BCD = bnum mod 10^DIGITS (truncation is exact).
- valid is never asserted outside DONE. BCD and ovf change only on the DONE edge or on reset.

Optional Feature:
- Macro: BIN2BCD_SATURATE_EN.
- Defined: when the sticky carry is set, BCD is loaded with all digits = 9 (16'h9999 by default) and ovf=1.
- Undefined: BCD is loaded with the truncated low DIGITS digits (bnum mod 10^DIGITS) and ovf=1.
- In both builds, results with ovf=0 are identical.

Test Plan:
- Reset then idle: reset=0 for 3 cycles, release -> BCD=16'h0000, ovf=0, valid=0, busy=0; no valid pulse for 50 idle cycles.
- Nominal: start pulse with bnum=1234 at edge 0 -> busy=1 for edges 0..20, one-cycle valid after edge 21, BCD=16'h1234, ovf=0. Also bnum=0 -> 16'h0000; bnum=9999 -> 16'h9999, ovf=0.
- Overflow boundary: bnum=10000 -> ovf=1; BCD=16'h9999 with BIN2BCD_SATURATE_EN, 16'h0000 without. bnum=1048575 -> ovf=1; BCD=16'h9999 with the macro, 16'h8575 without.
- Busy rejection: start bnum=42, then at edges 5 and 20 assert start with bnum=7777 -> single valid pulse with BCD=16'h0042. Back-to-back start at edge 22 with bnum=7777 -> BCD=16'h7777 after edge 43.
- Reset mid-operation: start bnum=5678, pull reset low at edge 10 for 2 cycles -> BCD=0, ovf=0, busy=0 immediately; no valid pulse afterwards; next start bnum=5678 -> 16'h5678 after 21 edges.
- Input capture: start bnum=321, then change bnum every cycle during SHIFT -> result BCD=16'h0321.

Source files
------------

// File: rtl/freq_bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Define BIN2BCD_SATURATE_EN to force all-nines on overflow instead of truncation.
module freq_bin2bcd_seq #(
    parameter int unsigned BIN_W  = 20,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bnum,
    output logic                  busy,
    output logic                  valid,
    output logic [4*DIGITS-1:0]   BCD,
    output logic                  ovf
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [BIN_W-1:0]   r_sh;
    logic [BCD_W-1:0]   r_acc;
    logic [BCD_W-1:0]   w_adj;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_ovf;
    logic               r_valid;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_SHIFT;
            S_SHIFT: if (r_cnt == LAST_CNT) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Add-3 correction on every nibble that would reach 10 or more after doubling
    always_comb begin
        w_adj = r_acc;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (r_acc[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_sh    <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_bcd   <= '0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sh    <= bnum;
                        r_acc   <= '0;
                        r_carry <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                S_SHIFT: begin
                    // A bit leaving the top digit means the value no longer fits the display
                    {r_acc, r_sh} <= {w_adj[BCD_W-2:0], r_sh, 1'b0};
                    r_carry       <= r_carry | w_adj[BCD_W-1];
                    r_cnt         <= r_cnt + 1'b1;
                end
                S_DONE: begin
`ifdef BIN2BCD_SATURATE_EN
                    r_bcd <= r_carry ? {DIGITS{4'h9}} : r_acc;
`else
                    r_bcd <= r_acc;
`endif
                    r_ovf   <= r_carry;
                    r_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy  = (r_state != S_IDLE);
    assign valid = r_valid;
    assign BCD   = r_bcd;
    assign ovf   = r_ovf;

endmodule
